i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Register-transaction sequencer that sits directly upstream of the I2C master command interface. Accepts one host request (register write or register read), expands it into the START/WRITE/RESTART/READ/STOP command sequence, issues each command to the master with a one-cycle write strobe, and returns read data and ACK/timeout status as a one-cycle response.

## Interface
Parameters:
- TIMEOUT, 16'd50000, cycles allowed between a command strobe and its done_tick_in before abort

Ports:
- clk  in  1  system clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid_in  in  1  host request valid
- req_ready_out  out  1  sequencer can accept a request
- req_rw_in  in  1  0 = register write, 1 = register read
- req_dev_addr_in  in  7  7-bit device address
- req_reg_addr_in  in  8  register address
- req_wdata_in  in  8  write data (ignored for reads)
- rsp_valid_out  out  1  one-cycle response pulse
- rsp_rdata_out  out  8  read byte (0 for writes)
- rsp_nack_out  out  1  a device byte was NACKed
- rsp_timeout_out  out  1  a command timed out
- cmd_out  out  3  command to master, encodings k_START_CMD/k_WRITE_CMD/k_READ_CMD/k_STOP_CMD/k_RESTART_CMD from include/i2c.vh
- din_out  out  8  byte for WRITE; for READ, din_out[0]=1 requests NACK (last byte)
- wr_i2c_out  out  1  one-cycle command strobe
- ready_in  in  1  master ready to take a command
- done_tick_in  in  1  one-cycle pulse: current command complete
- ack_in  in  1  ACK bit of last byte, 0 = ACK; valid with done_tick_in
- dout_in  in  8  read byte; valid with done_tick_in

## Operation
- States: IDLE, START, ADDR_W, REG, WDATA, RESTART, ADDR_R, READ, STOP, RESP. Every command state has ISSUE and WAIT phases.
- IDLE: req_ready_out=1. On req_valid_in: latch all req_* fields, clear status, go to START.
- ISSUE: when ready_in=1, pulse wr_i2c_out for exactly one cycle with cmd_out/din_out; clear timeout counter; enter WAIT. cmd_out/din_out hold until the next ISSUE.
- WAIT: on done_tick_in, advance. Counter increments each WAIT cycle; reaching TIMEOUT sets timeout flag and goes to STOP (from STOP itself: go to RESP).
- Write sequence: START, ADDR_W (din={dev,0}), REG (din=reg), WDATA (din=wdata), STOP.
- Read sequence: START, ADDR_W, REG, RESTART, ADDR_R (din={dev,1}), READ (din=8'h01), STOP.
- ADDR_W/REG/WDATA/ADDR_R: done_tick_in with ack_in=1 sets nack flag, jumps to STOP, skips remaining bytes.
- READ: capture dout_in on done_tick_in into rdata.
- STOP done → RESP: rsp_valid_out=1 one cycle with rdata/nack/timeout, then IDLE.
- done_tick_in outside WAIT, or ready_in changes outside ISSUE: ignored.

## Timing
- Reset (asynchronous, immediate): state IDLE, req_ready_out=1, wr_i2c_out=0, cmd_out=k_START_CMD, din_out=0, rsp_valid_out=0, rsp_rdata_out=0, rsp_nack_out=0, rsp_timeout_out=0, counter=0. Reset mid-transaction abandons it; no STOP is issued, no response.
- Request accept: req_ready_out drops the cycle after acceptance; earliest wr_i2c_out (START) is the next cycle if ready_in=1.
- Command issue: wr_i2c_out asserted in the first ISSUE cycle with ready_in=1; never two strobes without an intervening done_tick_in or timeout.
- Advance: next ISSUE state entered the cycle after done_tick_in; strobe earliest one cycle later.
- rsp_valid_out: the cycle after STOP's done_tick_in (or STOP timeout); req_ready_out returns high the cycle after that. rsp_* data remain stable until the next acceptance.
- Timeout: counter 16-bit, saturates; abort when count == TIMEOUT while in WAIT.
- Write with all ACKs: exactly 5 strobes; read: exactly 7.

## Test plan
- Write dev=7'h50 reg=8'h10 data=8'hA5, master ACKs all -> strobes START, WRITE 8'hA0, WRITE 8'h10, WRITE 8'hA5, STOP; rsp_valid_out one pulse, nack=0, timeout=0, rdata=0.
- Read dev=7'h50 reg=8'h20, dout_in=8'h3C on READ done -> strobes START, WRITE 8'hA0, WRITE 8'h20, RESTART, WRITE 8'hA1, READ din 8'h01, STOP; rsp_rdata_out=8'h3C.
- Write with ack_in=1 on address byte -> next strobe is STOP (3 strobes total: START, WRITE, STOP); rsp_nack_out=1.
- TIMEOUT=16 bench, withhold done_tick_in after REG strobe -> STOP strobe issued after 16 WAIT cycles; rsp_timeout_out=1.
- Hold ready_in=0 for 10 cycles in ISSUE -> no strobe until ready_in rises; exactly one strobe then; req_valid_in pulses during busy are not accepted.
- Assert reset_n=0 mid-read (during READ WAIT) -> all outputs return to reset values immediately; no rsp_valid_out; next request runs normally.

Source files
------------

// File: rtl/i2c_txn_sequencer.sv
// Register-transaction sequencer in front of an I2C master command port.
// Expands one host register write or read into START/WRITE/RESTART/READ/STOP commands and returns a one-cycle response.
//
// state   | meaning
// IDLE    | ready for a host request
// START   | issue/wait on START
// ADDR_W  | issue/wait on device address, write direction
// REG     | issue/wait on register address byte
// WDATA   | issue/wait on write data byte
// RESTART | issue/wait on repeated START
// ADDR_R  | issue/wait on device address, read direction
// READ    | issue/wait on single NACKed read byte
// STOP    | issue/wait on STOP
// RESP    | one-cycle response pulse
module i2c_txn_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid_in,
    output logic       req_ready_out,
    input  logic       req_rw_in,
    input  logic [6:0] req_dev_addr_in,
    input  logic [7:0] req_reg_addr_in,
    input  logic [7:0] req_wdata_in,
    output logic       rsp_valid_out,
    output logic [7:0] rsp_rdata_out,
    output logic       rsp_nack_out,
    output logic       rsp_timeout_out,
    output logic [2:0] cmd_out,
    output logic [7:0] din_out,
    output logic       wr_i2c_out,
    input  logic       ready_in,
    input  logic       done_tick_in,
    input  logic       ack_in,
    input  logic [7:0] dout_in
);

    localparam logic [2:0] k_START_CMD   = 3'b000;
    localparam logic [2:0] k_WRITE_CMD   = 3'b001;
    localparam logic [2:0] k_READ_CMD    = 3'b010;
    localparam logic [2:0] k_STOP_CMD    = 3'b011;
    localparam logic [2:0] k_RESTART_CMD = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG, S_WDATA,
        S_RESTART, S_ADDR_R, S_READ, S_STOP, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        wait_q, wait_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  reg_q, reg_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        nack_q, nack_d;
    logic        tmo_q, tmo_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [7:0]  din_q, din_d;
    logic        enter_issue;
    logic [15:0] cnt_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= 1'b0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            nack_q  <= 1'b0;
            tmo_q   <= 1'b0;
            cmd_q   <= k_START_CMD;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            nack_q  <= nack_d;
            tmo_q   <= tmo_d;
            cmd_q   <= cmd_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        cnt_d       = cnt_q;
        rw_d        = rw_q;
        dev_d       = dev_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        nack_d      = nack_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        din_d       = din_q;
        enter_issue = 1'b0;
        cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (req_valid_in) begin
                    rw_d        = req_rw_in;
                    dev_d       = req_dev_addr_in;
                    reg_d       = req_reg_addr_in;
                    wdata_d     = req_wdata_in;
                    rdata_d     = '0;
                    nack_d      = 1'b0;
                    tmo_d       = 1'b0;
                    state_d     = S_START;
                    enter_issue = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                wait_d  = 1'b0;
            end
            default: begin
                if (!wait_q) begin
                    if (ready_in) begin
                        wait_d = 1'b1;
                        cnt_d  = '0;
                    end
                end else if (done_tick_in) begin
                    enter_issue = 1'b1;
                    case (state_q)
                        S_START:   state_d = S_ADDR_W;
                        S_ADDR_W:  state_d = ack_in ? S_STOP : S_REG;
                        S_REG:     state_d = ack_in ? S_STOP : (rw_q ? S_RESTART : S_WDATA);
                        S_WDATA:   state_d = S_STOP;
                        S_RESTART: state_d = S_ADDR_R;
                        S_ADDR_R:  state_d = ack_in ? S_STOP : S_READ;
                        S_READ: begin
                            rdata_d = dout_in;
                            state_d = S_STOP;
                        end
                        default: begin
                            state_d     = S_RESP;
                            enter_issue = 1'b0;
                        end
                    endcase
                    // ACK is only meaningful on bytes the device receives
                    if (ack_in && (state_q inside {S_ADDR_W, S_REG, S_WDATA, S_ADDR_R})) begin
                        nack_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TIMEOUT) begin
                        tmo_d = 1'b1;
                        if (state_q == S_STOP) begin
                            state_d = S_RESP;
                        end else begin
                            state_d     = S_STOP;
                            enter_issue = 1'b1;
                        end
                    end
                end
            end
        endcase

        if (enter_issue) begin
            wait_d = 1'b0;
            case (state_d)
                S_START:   begin cmd_d = k_START_CMD;   din_d = 8'h00;          end
                S_ADDR_W:  begin cmd_d = k_WRITE_CMD;   din_d = {dev_q, 1'b0};  end
                S_REG:     begin cmd_d = k_WRITE_CMD;   din_d = reg_q;          end
                S_WDATA:   begin cmd_d = k_WRITE_CMD;   din_d = wdata_q;        end
                S_RESTART: begin cmd_d = k_RESTART_CMD; din_d = 8'h00;          end
                S_ADDR_R:  begin cmd_d = k_WRITE_CMD;   din_d = {dev_q, 1'b1};  end
                S_READ:    begin cmd_d = k_READ_CMD;    din_d = 8'h01;          end
                S_STOP:    begin cmd_d = k_STOP_CMD;    din_d = 8'h00;          end
                default:   begin cmd_d = cmd_q;         din_d = din_q;          end
            endcase
        end
    end

    always_comb begin
        req_ready_out = (state_q == S_IDLE);
        rsp_valid_out = (state_q == S_RESP);
        wr_i2c_out    = (state_q != S_IDLE) && (state_q != S_RESP) && !wait_q && ready_in;
    end

    assign cmd_out         = cmd_q;
    assign din_out         = din_q;
    assign rsp_rdata_out   = rdata_q;
    assign rsp_nack_out    = nack_q;
    assign rsp_timeout_out = tmo_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: a scripted I2C master responder plus a transaction-level model of the
// expected command list and response, compared every cycle against the DUT.
`timescale 1ns/1ps
module tb_i2c_txn_sequencer;

    localparam logic [2:0] C_START = 3'd0, C_WR = 3'd1, C_RD = 3'd2, C_STOP = 3'd3, C_RESTART = 3'd4;
    localparam logic [15:0] TMO = 16'd16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid_in = 1'b0, req_ready_out, req_rw_in = 1'b0;
    logic [6:0] req_dev_addr_in = '0;
    logic [7:0] req_reg_addr_in = '0, req_wdata_in = '0;
    logic       rsp_valid_out, rsp_nack_out, rsp_timeout_out;
    logic [7:0] rsp_rdata_out;
    logic [2:0] cmd_out;
    logic [7:0] din_out;
    logic       wr_i2c_out;
    logic       ready_in = 1'b1, done_tick_in = 1'b0, ack_in = 1'b0;
    logic [7:0] dout_in = '0;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_rw_in(req_rw_in),
        .req_dev_addr_in(req_dev_addr_in), .req_reg_addr_in(req_reg_addr_in), .req_wdata_in(req_wdata_in),
        .rsp_valid_out(rsp_valid_out), .rsp_rdata_out(rsp_rdata_out), .rsp_nack_out(rsp_nack_out),
        .rsp_timeout_out(rsp_timeout_out), .cmd_out(cmd_out), .din_out(din_out), .wr_i2c_out(wr_i2c_out),
        .ready_in(ready_in), .done_tick_in(done_tick_in), .ack_in(ack_in), .dout_in(dout_in)
    );

    typedef struct { logic [7:0] rdata; logic nack; logic tmo; } rsp_t;

    int         n_assert = 0, n_fail = 0, n_strobe = 0, cyc = 0;
    int         ready_mode = 1;   // 0 random, 1 forced high, 2 forced low
    bit         idle_m = 1'b1;
    rsp_t       last_rsp = '{8'h00, 1'b0, 1'b0};
    logic [2:0] exp_cmd_q[$];
    logic [7:0] exp_din_q[$];
    rsp_t       exp_rsp_q[$];
    logic [2:0] obs_cmd[8];
    logic [7:0] obs_din[8];
    int         st_cyc[8];
    int         obs_n;
    logic [7:0] got_rdata;
    logic       got_nack, got_tmo;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       ready_in = ($urandom_range(0, 3) != 0);
            2:       ready_in = 1'b0;
            default: ready_in = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Per-cycle comparison against the expected command and response queues
    always @(negedge clk) begin
        logic [2:0] ec;
        logic [7:0] ed;
        rsp_t       er;
        if (reset_n !== 1'b1) begin
            idle_m   = 1'b1;
            last_rsp = '{8'h00, 1'b0, 1'b0};
        end else begin
            check("req_ready", req_ready_out, idle_m);
            if (wr_i2c_out) begin
                n_strobe++;
                check("strobe_needs_ready", ready_in, 1'b1);
                if (exp_cmd_q.size() == 0) note_fail("unexpected_strobe");
                else begin
                    ec = exp_cmd_q.pop_front();
                    ed = exp_din_q.pop_front();
                    check("cmd", cmd_out, ec);
                    if (ec == C_WR || ec == C_RD) check("din", din_out, ed);
                end
            end
            if (rsp_valid_out) begin
                if (exp_rsp_q.size() == 0) note_fail("unexpected_rsp");
                else begin
                    er = exp_rsp_q.pop_front();
                    check("rsp_rdata", rsp_rdata_out, er.rdata);
                    check("rsp_nack", rsp_nack_out, er.nack);
                    check("rsp_timeout", rsp_timeout_out, er.tmo);
                    check("rsp_cmds_left", exp_cmd_q.size(), 0);
                    last_rsp = er;
                end
            end else if (idle_m) begin
                check("rsp_hold_rdata", rsp_rdata_out, last_rsp.rdata);
                check("rsp_hold_nack", rsp_nack_out, last_rsp.nack);
                check("rsp_hold_tmo", rsp_timeout_out, last_rsp.tmo);
            end
            if (idle_m && req_valid_in) idle_m = 1'b0;
            else if (rsp_valid_out) idle_m = 1'b1;
        end
    end

    task automatic check_rst(input string tag);
        check({tag, "_ready"}, req_ready_out, 1'b1);
        check({tag, "_wr"}, wr_i2c_out, 1'b0);
        check({tag, "_cmd"}, cmd_out, C_START);
        check({tag, "_din"}, din_out, 8'h00);
        check({tag, "_rsp_valid"}, rsp_valid_out, 1'b0);
        check({tag, "_rsp_rdata"}, rsp_rdata_out, 8'h00);
        check({tag, "_rsp_nack"}, rsp_nack_out, 1'b0);
        check({tag, "_rsp_tmo"}, rsp_timeout_out, 1'b0);
    endtask

    // kind: 0 clean, 1 NACK at command index fpos, 2 no done_tick for command fpos
    task automatic run_txn(input bit rw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd,
                           input logic [7:0] rb, input int kind, input int fpos, input int abort_at,
                           input bit busy_poke);
        logic [2:0] fc[8];
        logic [7:0] fd[8];
        logic [2:0] ec[8];
        logic [7:0] ed[8];
        int         flen, elen, s0;
        bit         got;
        rsp_t       er;
        if (!rw) begin
            fc[0] = C_START; fd[0] = 8'h00;
            fc[1] = C_WR;    fd[1] = {dev, 1'b0};
            fc[2] = C_WR;    fd[2] = rg;
            fc[3] = C_WR;    fd[3] = wd;
            fc[4] = C_STOP;  fd[4] = 8'h00;
            flen = 5;
        end else begin
            fc[0] = C_START;   fd[0] = 8'h00;
            fc[1] = C_WR;      fd[1] = {dev, 1'b0};
            fc[2] = C_WR;      fd[2] = rg;
            fc[3] = C_RESTART; fd[3] = 8'h00;
            fc[4] = C_WR;      fd[4] = {dev, 1'b1};
            fc[5] = C_RD;      fd[5] = 8'h01;
            fc[6] = C_STOP;    fd[6] = 8'h00;
            flen = 7;
        end
        elen = 0;
        for (int i = 0; i < flen; i++) begin
            if (kind != 0 && i > fpos) break;
            ec[elen] = fc[i]; ed[elen] = fd[i]; elen++;
        end
        if (kind != 0 && fpos != flen - 1) begin
            ec[elen] = C_STOP; ed[elen] = 8'h00; elen++;
        end
        er.rdata = (rw && (kind == 0 || fpos > 5)) ? rb : 8'h00;
        er.nack  = (kind == 1);
        er.tmo   = (kind == 2);
        for (int i = 0; i < elen; i++) begin
            exp_cmd_q.push_back(ec[i]);
            exp_din_q.push_back(ed[i]);
        end
        if (abort_at < 0) exp_rsp_q.push_back(er);

        got = 1'b0;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready_out === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) note_fail("req_ready_wait_expired");
        @(posedge clk); #1;
        req_valid_in = 1'b1; req_rw_in = rw; req_dev_addr_in = dev;
        req_reg_addr_in = rg; req_wdata_in = wd;
        if (busy_poke) ready_mode = 2;
        @(posedge clk); #1;
        req_valid_in = 1'b0; req_rw_in = ~rw; req_dev_addr_in = 7'($urandom);
        req_reg_addr_in = 8'($urandom); req_wdata_in = 8'($urandom);
        if (busy_poke) begin
            s0 = n_strobe;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                req_valid_in = ~req_valid_in;
                req_dev_addr_in = 7'($urandom);
                req_rw_in = ~req_rw_in;
            end
            req_valid_in = 1'b0;
            check("hold_no_strobe", n_strobe - s0, 0);
            ready_mode = 1;
        end

        obs_n = 0;
        for (int n = 0; n < elen; n++) begin
            got = 1'b0;
            for (int w = 0; w < 200; w++) begin
                @(negedge clk);
                if (wr_i2c_out === 1'b1) begin got = 1'b1; break; end
            end
            if (!got) begin note_fail("strobe_wait_expired"); break; end
            st_cyc[n] = cyc; obs_cmd[n] = cmd_out; obs_din[n] = din_out; obs_n++;
            if (n == abort_at) begin
                repeat (2) @(negedge clk);
                #2 reset_n = 1'b0;
                #1 check_rst("abort");
                exp_cmd_q.delete(); exp_din_q.delete(); exp_rsp_q.delete();
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
                repeat (3) @(negedge clk);
                return;
            end
            if (kind == 2 && n == fpos) continue;
            repeat ($urandom_range(0, 4)) @(posedge clk);
            @(posedge clk); #1;
            done_tick_in = 1'b1;
            ack_in  = (kind == 1 && n == fpos) ? 1'b1 : ((ec[n] == C_WR) ? 1'b0 : 1'($urandom));
            dout_in = (ec[n] == C_RD) ? rb : 8'($urandom);
            @(posedge clk); #1;
            done_tick_in = 1'b0; ack_in = 1'($urandom); dout_in = 8'($urandom);
        end

        got = 1'b0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk);
            if (rsp_valid_out === 1'b1) begin got = 1'b1; break; end
        end
        if (!got) note_fail("rsp_wait_expired");
        got_rdata = rsp_rdata_out; got_nack = rsp_nack_out; got_tmo = rsp_timeout_out;
        @(posedge clk); #1;
        if ($urandom_range(0, 1) == 1) begin
            done_tick_in = 1'b1; ack_in = 1'b1;
            @(posedge clk); #1;
            done_tick_in = 1'b0; ack_in = 1'b0;
        end
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, kind, fpos;
        bit rw;
        repeat (3) @(posedge clk);
        #1 check_rst("reset");
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 0, -1, 1'b0);
        check("t1_nstrobes", obs_n, 5);
        check("t1_din1", obs_din[1], 8'hA0);
        check("t1_din3", obs_din[3], 8'hA5);
        check("t1_cmd4", obs_cmd[4], C_STOP);
        check("t1_rdata", got_rdata, 8'h00);

        run_txn(1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 0, 0, -1, 1'b0);
        check("t2_nstrobes", obs_n, 7);
        check("t2_cmd3", obs_cmd[3], C_RESTART);
        check("t2_din4", obs_din[4], 8'hA1);
        check("t2_rdata", got_rdata, 8'h3C);

        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 1, -1, 1'b0);
        check("t3_nstrobes", obs_n, 3);
        check("t3_cmd2", obs_cmd[2], C_STOP);
        check("t3_nack", got_nack, 1'b1);

        ready_mode = 1;
        run_txn(1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 2, 2, -1, 1'b0);
        check("t4_nstrobes", obs_n, 4);
        check("t4_cmd3", obs_cmd[3], C_STOP);
        check("t4_gap", st_cyc[3] - st_cyc[2], 17);
        check("t4_tmo", got_tmo, 1'b1);

        run_txn(1'b0, 7'h2B, 8'h33, 8'h5A, 8'h00, 0, 0, -1, 1'b1);
        check("t5_nstrobes", obs_n, 5);

        ready_mode = 0;
        run_txn(1'b1, 7'h50, 8'h20, 8'h00, 8'h77, 0, 0, 5, 1'b0);
        run_txn(1'b1, 7'h11, 8'h44, 8'h00, 8'hC3, 0, 0, -1, 1'b0);
        check("t7_rdata", got_rdata, 8'hC3);

        for (int t = 0; t < 40; t++) begin
            rw = 1'($urandom);
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
            if (kind == 1) begin
                fpos = $urandom_range(1, 3);
                if (rw && fpos == 3) fpos = 4;
            end else fpos = $urandom_range(0, rw ? 6 : 4);
            run_txn(rw, 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), kind, fpos, -1, 1'b0);
        end

        repeat (5) @(posedge clk);
        check("end_cmds_left", exp_cmd_q.size(), 0);
        check("end_rsps_left", exp_rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
